// File: rtl/water_heater_ctrl.sv
// Water heater controller: latches the wash target temperature, runs the
// heater element with a hysteresis band, reports when the water is at
// temperature and raises timeout / over-temperature faults.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE
// (and only when stop is low); stop and clear_fault are level commands
// sampled on each clk edge; sensed_temp is consumed only in cycles where
// sensed_valid is high. There is no backpressure; every output is a flop.
module water_heater_ctrl #(
    parameter int HYST           = 2,
    parameter int SETTLE_SAMPLES = 3,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int MAX_TEMP       = 90,
    parameter int COLD_LIMIT     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear_fault,
    input  logic [6:0] target_temp,
    input  logic [6:0] sensed_temp,
    input  logic       sensed_valid,
    output logic       heater_on,
    output logic       temp_reached,
    output logic       busy,
    output logic       heat_fault,
    output logic [1:0] fault_code,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HEAT  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_FAULT = 3'd3;
    localparam logic [2:0] S_COLD  = 3'd4;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_TIMEOUT = 2'd1;
    localparam logic [1:0] FC_OVER    = 2'd2;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int SW = $clog2(SETTLE_SAMPLES + 1);

    logic [2:0]    state_q, state_d;
    logic [6:0]    tgt_q, tgt_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          heater_q, heater_d;
    logic          reached_q, reached_d;
    logic          busy_q, busy_d;
    logic          fault_q, fault_d;
    logic [1:0]    fcode_q, fcode_d;

    logic       over_temp;
    logic       sample_hit;
    logic [6:0] hyst_lo;

    assign over_temp  = sensed_valid && (sensed_temp > 7'(MAX_TEMP));
    assign sample_hit = sensed_valid && (sensed_temp >= tgt_q);
    // Lower hysteresis threshold saturates at zero for very low targets.
    assign hyst_lo    = (tgt_q > 7'(HYST)) ? (tgt_q - 7'(HYST)) : 7'd0;

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        heater_d  = heater_q;
        reached_d = reached_q;
        fcode_d   = fcode_q;
        case (state_q)
            S_IDLE: begin
                heater_d  = 1'b0;
                reached_d = 1'b0;
                settle_d  = '0;
                tmo_d     = '0;
                if (start && !stop) begin
                    tgt_d = target_temp;
                    if (target_temp <= 7'(COLD_LIMIT)) begin
                        state_d = S_COLD;
                    end else begin
                        state_d  = S_HEAT;
                        heater_d = 1'b1;
                    end
                end
            end
            S_HEAT: begin
                heater_d = 1'b1;
                if (over_temp) begin
                    state_d = S_FAULT;  fcode_d = FC_OVER;
                    heater_d = 1'b0;    reached_d = 1'b0;
                    settle_d = '0;      tmo_d = '0;
                end else if (stop) begin
                    state_d = S_IDLE;
                    heater_d = 1'b0;    reached_d = 1'b0;
                    settle_d = '0;      tmo_d = '0;
                end else if (sample_hit && settle_q == SW'(SETTLE_SAMPLES - 1)) begin
                    state_d = S_HOLD;
                    heater_d = 1'b0;    reached_d = 1'b1;
                    settle_d = '0;      tmo_d = '0;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_FAULT;  fcode_d = FC_TIMEOUT;
                    heater_d = 1'b0;    reached_d = 1'b0;
                    settle_d = '0;      tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (sensed_valid) begin
                        settle_d = sample_hit ? settle_q + SW'(1) : '0;
                    end
                end
            end
            S_HOLD: begin
                reached_d = 1'b1;
                if (over_temp) begin
                    state_d = S_FAULT;  fcode_d = FC_OVER;
                    heater_d = 1'b0;    reached_d = 1'b0;
                end else if (stop) begin
                    state_d = S_IDLE;
                    heater_d = 1'b0;    reached_d = 1'b0;
                end else if (sensed_valid && sensed_temp < hyst_lo) begin
                    heater_d = 1'b1;
                end else if (sample_hit) begin
                    heater_d = 1'b0;
                end
            end
            S_COLD: begin
                heater_d = 1'b0;
                if (over_temp) begin
                    state_d = S_FAULT;  fcode_d = FC_OVER;
                    reached_d = 1'b0;
                end else if (stop) begin
                    state_d = S_IDLE;
                    reached_d = 1'b0;
                end else begin
                    reached_d = 1'b1;
                end
            end
            S_FAULT: begin
                heater_d  = 1'b0;
                reached_d = 1'b0;
                if (clear_fault) begin
                    state_d = S_IDLE;
                    fcode_d = FC_NONE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                heater_d  = 1'b0;
                reached_d = 1'b0;
                fcode_d   = FC_NONE;
                settle_d  = '0;
                tmo_d     = '0;
            end
        endcase
        busy_d  = (state_d == S_HEAT) || (state_d == S_HOLD) || (state_d == S_COLD);
        fault_d = (state_d == S_FAULT);
    end

    // State and output registers; reset drops the heater without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tgt_q     <= '0;
            settle_q  <= '0;
            tmo_q     <= '0;
            heater_q  <= 1'b0;
            reached_q <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
            fcode_q   <= FC_NONE;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            settle_q  <= settle_d;
            tmo_q     <= tmo_d;
            heater_q  <= heater_d;
            reached_q <= reached_d;
            busy_q    <= busy_d;
            fault_q   <= fault_d;
            fcode_q   <= fcode_d;
        end
    end

    assign heater_on    = heater_q;
    assign temp_reached = reached_q;
    assign busy         = busy_q;
    assign heat_fault   = fault_q;
    assign fault_code   = fcode_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_water_heater_ctrl.sv
// Bench for water_heater_ctrl: directed scenarios followed by a random phase,
// all compared against a behavioural model of the heater rules.
module tb_water_heater_ctrl;

    localparam int HYST   = 2;
    localparam int SETTLE = 3;
    localparam int TMO    = 50;
    localparam int MAXT   = 90;
    localparam int COLDL  = 10;

    logic       clk = 1'b0;
    logic       reset, start, stop, clear_fault, sensed_valid;
    logic [6:0] target_temp, sensed_temp;
    logic       heater_on, temp_reached, busy, heat_fault;
    logic [1:0] fault_code;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Model: phase names follow the documented state codes.
    int         m_state, m_hits, m_heat_cycles;
    logic [6:0] m_tgt;
    logic       m_heater, m_reached;
    logic [1:0] m_code;

    water_heater_ctrl #(
        .HYST(HYST), .SETTLE_SAMPLES(SETTLE), .TIMEOUT_CYCLES(TMO),
        .MAX_TEMP(MAXT), .COLD_LIMIT(COLDL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .clear_fault(clear_fault), .target_temp(target_temp),
        .sensed_temp(sensed_temp), .sensed_valid(sensed_valid),
        .heater_on(heater_on), .temp_reached(temp_reached), .busy(busy),
        .heat_fault(heat_fault), .fault_code(fault_code), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_hits = 0; m_heat_cycles = 0; m_tgt = '0;
        m_heater = 1'b0; m_reached = 1'b0; m_code = 2'd0;
    endtask

    task automatic to_idle();
        m_state = 0; m_heater = 1'b0; m_reached = 1'b0;
    endtask

    task automatic to_fault(input logic [1:0] code);
        m_state = 3; m_code = code; m_heater = 1'b0; m_reached = 1'b0;
    endtask

    // Applies one clock edge worth of the controller rules.
    task automatic model_step(input logic s, input logic st, input logic clr,
                              input logic [6:0] tt, input logic [6:0] sn, input logic v);
        bit hot;
        int lo;
        hot = v && (int'(sn) > MAXT);
        case (m_state)
            0: if (s && !st) begin
                m_tgt = tt; m_hits = 0; m_heat_cycles = 0;
                if (int'(tt) <= COLDL) m_state = 4;
                else begin m_state = 1; m_heater = 1'b1; end
            end
            1: if (hot) to_fault(2'd2);
               else if (st) to_idle();
               else begin
                   if (v) m_hits = (sn >= m_tgt) ? m_hits + 1 : 0;
                   m_heat_cycles++;
                   if (m_hits == SETTLE) begin
                       m_state = 2; m_reached = 1'b1; m_heater = 1'b0;
                   end else if (m_heat_cycles == TMO) begin
                       to_fault(2'd1);
                   end
               end
            2: if (hot) to_fault(2'd2);
               else if (st) to_idle();
               else if (v) begin
                   lo = int'(m_tgt) - HYST;
                   if (lo < 0) lo = 0;
                   if (int'(sn) < lo) m_heater = 1'b1;
                   else if (sn >= m_tgt) m_heater = 1'b0;
               end
            4: if (hot) to_fault(2'd2);
               else if (st) to_idle();
               else m_reached = 1'b1;
            3: if (clr) begin m_state = 0; m_code = 2'd0; end
            default: ;
        endcase
    endtask

    task automatic check_all(input string where);
        chk({where, ".heater_on"},    8'(heater_on),    8'(m_heater));
        chk({where, ".temp_reached"}, 8'(temp_reached), 8'(m_reached));
        chk({where, ".busy"},         8'(busy),         8'(m_state == 1 || m_state == 2 || m_state == 4));
        chk({where, ".heat_fault"},   8'(heat_fault),   8'(m_state == 3));
        chk({where, ".fault_code"},   8'(fault_code),   8'(m_code));
        chk({where, ".state_dbg"},    8'(state_dbg),    8'(m_state));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare.
    task automatic cyc(input string where, input logic s, input logic st, input logic clr,
                       input logic [6:0] tt, input logic [6:0] sn, input logic v);
        start = s; stop = st; clear_fault = clr;
        target_temp = tt; sensed_temp = sn; sensed_valid = v;
        @(posedge clk);
        model_step(s, st, clr, tt, sn, v);
        #1;
        check_all(where);
    endtask

    initial begin
        int k;
        int sn_i;
        logic [6:0] tt_r;
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear_fault = 1'b0;
        target_temp = '0; sensed_temp = '0; sensed_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Heating ramp to 40 with a sample every 4 cycles.
        cyc("ramp_start", 1'b1, 1'b0, 1'b0, 7'd40, 7'd20, 1'b0);
        chk("ramp_heater_after_start", 8'(heater_on), 8'd1);
        k = 0;
        while (m_state != 2 && k < 200) begin
            sn_i = 20 + 3 * (k / 4);
            if (sn_i > 41) sn_i = 41;
            cyc("ramp", 1'b0, 1'b0, 1'b0, 7'd99, 7'(sn_i), (k % 4) == 3);
            k++;
        end
        chk("ramp_state_hold", 8'(state_dbg), 8'd2);
        chk("ramp_reached", 8'(temp_reached), 8'd1);
        chk("ramp_heater_off", 8'(heater_on), 8'd0);

        // Hysteresis around a 60 degree target.
        cyc("hyst_stop", 1'b0, 1'b1, 1'b0, 7'd0, 7'd40, 1'b0);
        cyc("hyst_start", 1'b1, 1'b0, 1'b0, 7'd60, 7'd40, 1'b0);
        repeat (3) cyc("hyst_settle", 1'b0, 1'b0, 1'b0, 7'd0, 7'd60, 1'b1);
        cyc("hyst_58", 1'b0, 1'b0, 1'b0, 7'd0, 7'd58, 1'b1);
        chk("hyst_58_heater", 8'(heater_on), 8'd0);
        cyc("hyst_57", 1'b0, 1'b0, 1'b0, 7'd0, 7'd57, 1'b1);
        chk("hyst_57_heater", 8'(heater_on), 8'd1);
        cyc("hyst_59", 1'b0, 1'b0, 1'b0, 7'd0, 7'd59, 1'b1);
        chk("hyst_59_heater", 8'(heater_on), 8'd1);
        cyc("hyst_60", 1'b0, 1'b0, 1'b0, 7'd0, 7'd60, 1'b1);
        chk("hyst_60_heater", 8'(heater_on), 8'd0);
        chk("hyst_reached", 8'(temp_reached), 8'd1);

        // Cold wash.
        cyc("cold_stop", 1'b0, 1'b1, 1'b0, 7'd0, 7'd20, 1'b0);
        cyc("cold_start", 1'b1, 1'b0, 1'b0, 7'd10, 7'd20, 1'b0);
        chk("cold_state", 8'(state_dbg), 8'd4);
        chk("cold_reached_early", 8'(temp_reached), 8'd0);
        cyc("cold_wait", 1'b0, 1'b0, 1'b0, 7'd0, 7'd20, 1'b1);
        chk("cold_reached", 8'(temp_reached), 8'd1);
        cyc("cold_end", 1'b0, 1'b1, 1'b0, 7'd0, 7'd20, 1'b0);
        chk("cold_end_reached", 8'(temp_reached), 8'd0);

        // Heating timeout.
        cyc("tmo_start", 1'b1, 1'b0, 1'b0, 7'd60, 7'd30, 1'b0);
        repeat (TMO - 1) cyc("tmo_heat", 1'b0, 1'b0, 1'b0, 7'd0, 7'd30, 1'b1);
        chk("tmo_still_heat", 8'(state_dbg), 8'd1);
        cyc("tmo_edge", 1'b0, 1'b0, 1'b0, 7'd0, 7'd30, 1'b1);
        chk("tmo_state_fault", 8'(state_dbg), 8'd3);
        chk("tmo_code", 8'(fault_code), 8'd1);
        cyc("fault_start_ignored", 1'b1, 1'b1, 1'b0, 7'd60, 7'd30, 1'b0);
        chk("fault_held", 8'(state_dbg), 8'd3);
        cyc("fault_clear", 1'b0, 1'b0, 1'b1, 7'd0, 7'd30, 1'b0);
        chk("fault_cleared", 8'(state_dbg), 8'd0);

        // Over-temperature beats stop in HOLD.
        cyc("ot_start", 1'b1, 1'b0, 1'b0, 7'd40, 7'd40, 1'b0);
        repeat (3) cyc("ot_settle", 1'b0, 1'b0, 1'b0, 7'd0, 7'd40, 1'b1);
        cyc("ot_hit", 1'b0, 1'b1, 1'b0, 7'd0, 7'd95, 1'b1);
        chk("ot_state", 8'(state_dbg), 8'd3);
        chk("ot_code", 8'(fault_code), 8'd2);
        cyc("ot_clear", 1'b0, 1'b0, 1'b1, 7'd0, 7'd30, 1'b0);
        cyc("idle_start_stop", 1'b1, 1'b1, 1'b0, 7'd60, 7'd30, 1'b0);
        chk("idle_start_stop_state", 8'(state_dbg), 8'd0);

        // Asynchronous reset mid-heat.
        cyc("ar_start", 1'b1, 1'b0, 1'b0, 7'd60, 7'd30, 1'b0);
        cyc("ar_heat", 1'b0, 1'b0, 1'b0, 7'd0, 7'd30, 1'b1);
        chk("ar_heater_before", 8'(heater_on), 8'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("ar_heater_async", 8'(heater_on), 8'd0);
        check_all("ar_async");
        @(negedge clk);
        reset = 1'b0;

        // Random phase.
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 4))
                0: tt_r = 7'd10;
                1: tt_r = 7'd30;
                2: tt_r = 7'd40;
                3: tt_r = 7'd60;
                default: tt_r = 7'($urandom_range(0, 127));
            endcase
            if ($urandom_range(0, 63) == 0) sn_i = $urandom_range(85, 127);
            else sn_i = int'(m_state == 0 ? tt_r : m_tgt) + $urandom_range(0, 10) - 6;
            if (sn_i < 0) sn_i = 0;
            if (sn_i > 127) sn_i = 127;
            cyc("rand", $urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0,
                $urandom_range(0, 7) == 0, tt_r, 7'(sn_i), $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
